// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-channel linear brightness fader with PWM LED drive.
// Levels move one step per prescaler tick; duty is latched only at period end.
module led_pwm_fader #(
    parameter int N_LED    = 5,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic [N_LED:1]   led_in,
    input  logic             enable,
    output logic [N_LED:1]   led_out,
    output logic             pwm_sync,
    output logic             busy
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [N_LED:1]                 led_q, led_d;
    logic [PWM_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]              step_cnt_q, step_cnt_d;
    logic [N_LED:1][PWM_BITS-1:0]   lvl_q, lvl_d;
    logic [N_LED:1][PWM_BITS-1:0]   duty_q, duty_d;
    logic [N_LED:1][PWM_BITS-1:0]   tgt;
    logic [N_LED:1]                 led_out_q, led_out_d;
    logic                           pwm_sync_q, pwm_sync_d;
    logic                           busy_q, busy_d;
    logic                           step_tick;

    // Each channel's target is full on or full off from the captured pattern
    always_comb begin
        tgt = '0;
        for (int i = 1; i <= N_LED; i++) begin
            tgt[i] = led_q[i] ? MAX : '0;
        end
    end

    // Counters, level stepping, period-aligned duty latch and output decode
    always_comb begin
        led_d      = led_in;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        step_tick  = enable && (step_cnt_q == STEP_LAST);
        step_cnt_d = step_cnt_q;
        lvl_d      = lvl_q;
        duty_d     = duty_q;
        led_out_d  = '0;
        busy_d     = 1'b0;
        pwm_sync_d = (pwm_cnt_q == '0);

        if (enable) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        end

        for (int i = 1; i <= N_LED; i++) begin
            if (step_tick) begin
                unique case (1'b1)
                    (lvl_q[i] < tgt[i]): lvl_d[i] = lvl_q[i] + 1'b1;
                    (lvl_q[i] > tgt[i]): lvl_d[i] = lvl_q[i] - 1'b1;
                    default:             lvl_d[i] = lvl_q[i];
                endcase
            end
            if (pwm_cnt_q == MAX) begin
                duty_d[i] = lvl_q[i];
            end
            led_out_d[i] = (duty_q[i] == MAX) || (pwm_cnt_q < duty_q[i]);
            if (lvl_q[i] != tgt[i]) begin
                busy_d = 1'b1;
            end
        end
    end

    // State and registered outputs, synchronous active-low clear
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            led_q      <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            lvl_q      <= '0;
            duty_q     <= '0;
            led_out_q  <= '0;
            pwm_sync_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            led_q      <= led_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            lvl_q      <= lvl_d;
            duty_q     <= duty_d;
            led_out_q  <= led_out_d;
            pwm_sync_q <= pwm_sync_d;
            busy_q     <= busy_d;
        end
    end

    assign led_out  = led_out_q;
    assign pwm_sync = pwm_sync_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench with a cycle-level behavioural model.
// Directed fade scenarios followed by randomized pattern/enable/reset traffic.
module tb_led_pwm_fader;

    localparam int N  = 5;
    localparam int PB = 4;
    localparam int SD = 2;
    localparam int MX = (1 << PB) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N:1]   led_in = '0;
    logic [N:1]   led_out;
    logic         pwm_sync;
    logic         busy;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .N_LED(N),
        .PWM_BITS(PB),
        .STEP_DIV(SD)
    ) dut (
        .clk_100mhz(clk),
        .rst_n(rst_n),
        .led_in(led_in),
        .enable(enable),
        .led_out(led_out),
        .pwm_sync(pwm_sync),
        .busy(busy)
    );

    typedef struct packed {
        logic [N:1] led;
        logic       sync;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: time within the PWM period, enabled-cycle
    // count for the step prescaler, brightness and latched duty per channel.
    int       phase = 0;
    int       en_cnt = 0;
    int       lvl [1:N];
    int       duty [1:N];
    logic [N:1] pat = '0;

    initial begin
        for (int i = 1; i <= N; i++) begin
            lvl[i] = 0;
            duty[i] = 0;
        end
    end

    // Model: predict the outputs visible after each rising edge
    always @(posedge clk) begin
        exp_t e;
        int t;
        e = '0;
        if (!rst_n) begin
            phase = 0;
            en_cnt = 0;
            pat = '0;
            for (int i = 1; i <= N; i++) begin
                lvl[i] = 0;
                duty[i] = 0;
            end
        end else begin
            e.sync = (phase == 0);
            for (int i = 1; i <= N; i++) begin
                t = pat[i] ? MX : 0;
                e.led[i] = (duty[i] == MX) || (phase < duty[i]);
                if (lvl[i] != t) e.busy = 1'b1;
            end
            if (phase == MX) begin
                for (int i = 1; i <= N; i++) duty[i] = lvl[i];
            end
            if (enable && (en_cnt % SD == SD - 1)) begin
                for (int i = 1; i <= N; i++) begin
                    t = pat[i] ? MX : 0;
                    if (lvl[i] < t) lvl[i] = lvl[i] + 1;
                    else if (lvl[i] > t) lvl[i] = lvl[i] - 1;
                end
            end
            if (enable) en_cnt = en_cnt + 1;
            pat = led_in;
            phase = (phase + 1) % (MX + 1);
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest prediction
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({led_out, pwm_sync, busy} !== {e.led, e.sync, e.busy}) begin
                errs++;
                $display("FAIL outputs t=%0t got led=%b sync=%b busy=%b want led=%b sync=%b busy=%b",
                         $time, led_out, pwm_sync, busy, e.led, e.sync, e.busy);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lvl(input int v, input int lim);
        int k;
        k = 0;
        while (lvl[1] != v && k < lim) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (lvl[1] != v) begin
            errs++;
            $display("FAIL wait_lvl got=%0d want=%0d", lvl[1], v);
        end
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        led_in = '1;
        enable = 1'b0;
        step(5);

        rst_n = 1'b1;
        led_in = 5'b00001;
        enable = 1'b1;
        wait_lvl(15, 100);
        step(40);

        led_in = 5'b00000;
        wait_lvl(0, 100);
        led_in = 5'b00001;
        wait_lvl(4, 50);
        enable = 1'b0;
        step(64);

        enable = 1'b1;
        wait_lvl(7, 50);
        led_in = 5'b00000;
        wait_lvl(0, 50);
        step(40);

        led_in = 5'b10101;
        wait_lvl(9, 60);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(40);

        step(100);

        repeat (60) begin
            led_in = N'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 19) != 0);
            step($urandom_range(1, 40));
        end
        rst_n = 1'b1;
        step(5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
